// File: rtl/rtc_bus_ctrl_burst.sv
// PicoBlaze port-mapped controller for a multiplexed address/data RTC bus.
// Runs single or auto-incrementing burst transfers, with write and read data buffered in small FIFOs.
module rtc_bus_ctrl_burst #(
  parameter int         DW        = 8,
  parameter logic [7:0] PORT_BASE = 8'h00,
  parameter int         T_STROBE  = 4,
  parameter int         T_REC     = 2,
  parameter int         BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    port_id,
  input  logic [DW-1:0] in_dato,
  input  logic          write_strobe,
  input  logic          read_strobe,
  output logic          reg_a_d,
  output logic          reg_cs,
  output logic          reg_rd,
  output logic          reg_wr,
  output logic [DW-1:0] out_dato,
  output logic [7:0]    fin_lectura_escritura,
  inout  wire  [DW-1:0] dato
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_REC = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_DATA_REC = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam int AW   = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam int CW   = AW + 1;
  localparam int TMAX = (T_STROBE > T_REC) ? T_STROBE : T_REC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] TS_LAST = TW'(T_STROBE - 1);
  localparam logic [TW-1:0] TR_LAST = TW'(T_REC - 1);
  localparam logic [3:0]    REM_MAX = 4'(BURST_MAX - 1);
  localparam logic [CW-1:0] DEPTH   = CW'(BURST_MAX);
  localparam logic [7:0]    P_ADDR  = PORT_BASE;
  localparam logic [7:0]    P_DATA  = PORT_BASE + 8'd1;
  localparam logic [7:0]    P_CMD   = PORT_BASE + 8'd2;
  localparam logic [7:0]    P_STAT  = PORT_BASE + 8'd3;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    rem_q, rem_d;
  logic          dir_q, dir_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic [DW-1:0] wmem [BURST_MAX];
  logic [DW-1:0] rmem [BURST_MAX];
  logic [AW-1:0] wrd_q, wwr_q, rrd_q, rwr_q;
  logic [CW-1:0] wcnt_q, rcnt_q;

  logic          busy, wr_addr, wr_data, wr_cmd, rd_data, rd_stat;
  logic          cmd_start, cmd_clash, strobe_last, rec_last, data_exit;
  logic          w_empty, w_full, w_push, w_pop, r_empty, r_full, r_cap, r_pop;
  logic [DW-1:0] wr_word, dato_out;
  logic          dato_oe;
  logic [7:0]    status;

  assign busy      = (state_q != S_IDLE);
  assign wr_addr   = write_strobe && (port_id == P_ADDR);
  assign wr_data   = write_strobe && (port_id == P_DATA);
  assign wr_cmd    = write_strobe && (port_id == P_CMD) && in_dato[0];
  assign rd_data   = read_strobe && (port_id == P_DATA);
  assign rd_stat   = read_strobe && (port_id == P_STAT);
  assign cmd_start = wr_cmd && !busy;
  assign cmd_clash = wr_cmd && busy;

  assign strobe_last = (tcnt_q == TS_LAST);
  assign rec_last    = (tcnt_q == TR_LAST);
  assign data_exit   = (state_q == S_DATA) && strobe_last;

  assign w_empty = (wcnt_q == '0);
  assign w_full  = (wcnt_q == DEPTH);
  assign w_push  = wr_data && !w_full;
  assign w_pop   = data_exit && !dir_q && !w_empty;
  assign r_empty = (rcnt_q == '0);
  assign r_full  = (rcnt_q == DEPTH);
  assign r_cap   = data_exit && dir_q && !r_full;
  assign r_pop   = rd_data && !r_empty;
  assign wr_word = w_empty ? '0 : wmem[wrd_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    tcnt_d  = '0;
    rem_d   = rem_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (wr_addr) addr_d = in_dato;
        if (cmd_start) begin
          state_d = S_ADDR;
          dir_d   = in_dato[1];
          rem_d   = (in_dato[7:4] > REM_MAX) ? REM_MAX : in_dato[7:4];
        end
      end
      S_ADDR:
        if (strobe_last) state_d = S_ADDR_REC;
        else             tcnt_d  = tcnt_q + TW'(1);
      S_ADDR_REC:
        if (rec_last) state_d = S_DATA;
        else          tcnt_d  = tcnt_q + TW'(1);
      S_DATA:
        if (strobe_last) begin
          state_d = S_DATA_REC;
          if (!dir_q) hold_d = wr_word;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      S_DATA_REC:
        if (rec_last) begin
          // Decision point between transfers: advance the address, loop or finish.
          addr_d = addr_q + DW'(1);
          if (rem_q != 4'd0) begin
            rem_d   = rem_q - 4'd1;
            state_d = S_ADDR;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rd_stat) begin
      ovf_d = 1'b0;
      err_d = 1'b0;
    end
    if ((wr_data && w_full) || (data_exit && dir_q && r_full) ||
        (data_exit && !dir_q && w_empty))
      ovf_d = 1'b1;
    if (cmd_clash) err_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      wrd_q   <= '0;
      wwr_q   <= '0;
      wcnt_q  <= '0;
      rrd_q   <= '0;
      rwr_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      if (w_push) wwr_q <= wwr_q + AW'(1);
      if (w_pop)  wrd_q <= wrd_q + AW'(1);
      if (r_cap)  rwr_q <= rwr_q + AW'(1);
      if (r_pop)  rrd_q <= rrd_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   wcnt_q <= wcnt_q + CW'(1);
        2'b01:   wcnt_q <= wcnt_q - CW'(1);
        default: wcnt_q <= wcnt_q;
      endcase
      case ({r_cap, r_pop})
        2'b10:   rcnt_q <= rcnt_q + CW'(1);
        2'b01:   rcnt_q <= rcnt_q - CW'(1);
        default: rcnt_q <= rcnt_q;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; emptiness is tracked by the reset pointers and counts.
  always_ff @(posedge clk) begin
    if (w_push) wmem[wwr_q] <= in_dato;
    if (r_cap)  rmem[rwr_q] <= dato;
  end

  always_comb begin
    reg_cs   = 1'b1;
    reg_a_d  = 1'b1;
    reg_wr   = 1'b1;
    reg_rd   = 1'b1;
    dato_oe  = 1'b0;
    dato_out = '0;
    case (state_q)
      S_ADDR: begin
        reg_cs   = 1'b0;
        reg_a_d  = 1'b0;
        reg_wr   = 1'b0;
        dato_oe  = 1'b1;
        dato_out = addr_q;
      end
      S_ADDR_REC: begin
        reg_cs   = 1'b0;
        reg_a_d  = 1'b0;
        dato_oe  = 1'b1;
        dato_out = addr_q;
      end
      S_DATA: begin
        reg_cs = 1'b0;
        if (dir_q) begin
          reg_rd = 1'b0;
        end else begin
          reg_wr   = 1'b0;
          dato_oe  = 1'b1;
          dato_out = wr_word;
        end
      end
      S_DATA_REC: begin
        reg_cs   = 1'b0;
        dato_oe  = !dir_q;
        dato_out = hold_q;
      end
      default: ;
    endcase
  end

  assign dato = dato_oe ? dato_out : 'z;
  assign fin_lectura_escritura = (state_q == S_DONE) ? 8'h01 : 8'h00;
  assign status = {3'b000, err_q, ovf_q, !r_empty, w_empty, busy};

  always_comb begin
    out_dato = '0;
    if (port_id == P_DATA)      out_dato = r_empty ? '0 : rmem[rrd_q];
    else if (port_id == P_STAT) out_dato = DW'(status);
  end

endmodule
